// File: rtl/apb_fic_arbiter.sv
// Two-master APB3 arbiter sharing one slave port between MSS FIC_0 (M0) and a fabric master (M1).
// Transfers are serialised, re-issued with proper setup/access phases, and force-completed on slave timeout.
module apb_fic_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter bit FIXED_PRIORITY = 1'b0,
   parameter int TIMEOUT        = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic                  M0_PSEL,
   input  logic                  M0_PENABLE,
   input  logic                  M0_PWRITE,
   input  logic [ADDR_WIDTH-1:0] M0_PADDR,
   input  logic [DATA_WIDTH-1:0] M0_PWDATA,
   output logic                  M0_PREADY,
   output logic                  M0_PSLVERR,
   output logic [DATA_WIDTH-1:0] M0_PRDATA,
   input  logic                  M1_PSEL,
   input  logic                  M1_PENABLE,
   input  logic                  M1_PWRITE,
   input  logic [ADDR_WIDTH-1:0] M1_PADDR,
   input  logic [DATA_WIDTH-1:0] M1_PWDATA,
   output logic                  M1_PREADY,
   output logic                  M1_PSLVERR,
   output logic [DATA_WIDTH-1:0] M1_PRDATA,
   output logic                  S_PSEL,
   output logic                  S_PENABLE,
   output logic                  S_PWRITE,
   output logic [ADDR_WIDTH-1:0] S_PADDR,
   output logic [DATA_WIDTH-1:0] S_PWDATA,
   input  logic                  S_PREADY,
   input  logic                  S_PSLVERR,
   input  logic [DATA_WIDTH-1:0] S_PRDATA,
   output logic                  GRANT,
   output logic                  TIMEOUT_ERR
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t      state, state_next;
   logic [15:0] wait_cnt, wait_cnt_next;
   logic        last_grant;
   logic        take;
   logic        grant_win;
   logic        timeout_hit;

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      take          = 1'b0;
      grant_win     = 1'b0;
      timeout_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (M0_PSEL || M1_PSEL) begin
               take          = 1'b1;
               wait_cnt_next = '0;
               state_next    = SETUP;
               if (M0_PSEL && M1_PSEL)
                  grant_win = FIXED_PRIORITY ? 1'b0 : ~last_grant;
               else
                  grant_win = M1_PSEL;
            end
         end
         SETUP: state_next = ACCESS;
         ACCESS: begin
            if (S_PREADY) begin
               state_next = IDLE;
            end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT)) begin
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end else begin
               wait_cnt_next = wait_cnt + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         last_grant <= 1'b1;
         GRANT      <= 1'b0;
         S_PWRITE   <= 1'b0;
         S_PADDR    <= '0;
         S_PWDATA   <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (take) begin
            last_grant <= grant_win;
            GRANT      <= grant_win;
            S_PWRITE   <= grant_win ? M1_PWRITE : M0_PWRITE;
            S_PADDR    <= grant_win ? M1_PADDR  : M0_PADDR;
            S_PWDATA   <= grant_win ? M1_PWDATA : M0_PWDATA;
         end
      end
   end

   // Slave strobes follow the state directly, so a reset drops them at once.
   assign S_PSEL      = (state != IDLE);
   assign S_PENABLE   = (state == ACCESS);
   assign TIMEOUT_ERR = timeout_hit;

   logic in_access, done, ok_done;
   assign in_access = (state == ACCESS);
   assign done      = in_access & (S_PREADY | timeout_hit);
   assign ok_done   = in_access & S_PREADY;

   assign M0_PREADY  = done & ~GRANT & M0_PENABLE;
   assign M1_PREADY  = done &  GRANT & M1_PENABLE;
   assign M0_PRDATA  = (ok_done & ~GRANT) ? S_PRDATA : '0;
   assign M1_PRDATA  = (ok_done &  GRANT) ? S_PRDATA : '0;
   assign M0_PSLVERR = in_access & ~GRANT & (S_PREADY ? S_PSLVERR : timeout_hit);
   assign M1_PSLVERR = in_access &  GRANT & (S_PREADY ? S_PSLVERR : timeout_hit);

endmodule

// File: tb/tb_apb_fic_arbiter.sv
// Directed bench for apb_fic_arbiter: a round-robin instance with TIMEOUT=4 and a fixed-priority
// instance share the bench-driven master and slave stimulus.
module tb_apb_fic_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_psel, m0_penable, m0_pwrite;
   logic [31:0] m0_paddr, m0_pwdata;
   logic        m1_psel, m1_penable, m1_pwrite;
   logic [31:0] m1_paddr, m1_pwdata;
   logic        s_pready, s_pslverr;
   logic [31:0] s_prdata;

   logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
   logic [31:0] m0_prdata, m1_prdata;
   logic        s_psel, s_penable, s_pwrite, grant, timeout_err;
   logic [31:0] s_paddr, s_pwdata;

   logic        fp_m0_pready, fp_m0_pslverr, fp_m1_pready, fp_m1_pslverr;
   logic [31:0] fp_m0_prdata, fp_m1_prdata;
   logic        fp_s_psel, fp_s_penable, fp_s_pwrite, fp_grant, fp_timeout_err;
   logic [31:0] fp_s_paddr, fp_s_pwdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   apb_fic_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT(4)) dut (
      .PCLK(clk), .PRESETN(rst_n),
      .M0_PSEL(m0_psel), .M0_PENABLE(m0_penable), .M0_PWRITE(m0_pwrite),
      .M0_PADDR(m0_paddr), .M0_PWDATA(m0_pwdata),
      .M0_PREADY(m0_pready), .M0_PSLVERR(m0_pslverr), .M0_PRDATA(m0_prdata),
      .M1_PSEL(m1_psel), .M1_PENABLE(m1_penable), .M1_PWRITE(m1_pwrite),
      .M1_PADDR(m1_paddr), .M1_PWDATA(m1_pwdata),
      .M1_PREADY(m1_pready), .M1_PSLVERR(m1_pslverr), .M1_PRDATA(m1_prdata),
      .S_PSEL(s_psel), .S_PENABLE(s_penable), .S_PWRITE(s_pwrite),
      .S_PADDR(s_paddr), .S_PWDATA(s_pwdata),
      .S_PREADY(s_pready), .S_PSLVERR(s_pslverr), .S_PRDATA(s_prdata),
      .GRANT(grant), .TIMEOUT_ERR(timeout_err)
   );

   apb_fic_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
      .PCLK(clk), .PRESETN(rst_n),
      .M0_PSEL(m0_psel), .M0_PENABLE(m0_penable), .M0_PWRITE(m0_pwrite),
      .M0_PADDR(m0_paddr), .M0_PWDATA(m0_pwdata),
      .M0_PREADY(fp_m0_pready), .M0_PSLVERR(fp_m0_pslverr), .M0_PRDATA(fp_m0_prdata),
      .M1_PSEL(m1_psel), .M1_PENABLE(m1_penable), .M1_PWRITE(m1_pwrite),
      .M1_PADDR(m1_paddr), .M1_PWDATA(m1_pwdata),
      .M1_PREADY(fp_m1_pready), .M1_PSLVERR(fp_m1_pslverr), .M1_PRDATA(fp_m1_prdata),
      .S_PSEL(fp_s_psel), .S_PENABLE(fp_s_penable), .S_PWRITE(fp_s_pwrite),
      .S_PADDR(fp_s_paddr), .S_PWDATA(fp_s_pwdata),
      .S_PREADY(s_pready), .S_PSLVERR(s_pslverr), .S_PRDATA(s_prdata),
      .GRANT(fp_grant), .TIMEOUT_ERR(fp_timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic m_setup(input int idx, input logic [31:0] addr);
      if (idx == 0) begin
         m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = 1'b1; m0_paddr = addr; m0_pwdata = ~addr;
      end else begin
         m1_psel = 1'b1; m1_penable = 1'b0; m1_pwrite = 1'b1; m1_paddr = addr; m1_pwdata = ~addr;
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        wp, lp;
      logic [31:0] base;
      rst_n = 1'b0;
      m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
      m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;
      s_pready = 1'b1; s_pslverr = 1'b0; s_prdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      mid();
      check("rst_s_psel", s_psel, 0);
      check("rst_s_penable", s_penable, 0);
      check("rst_s_pwrite", s_pwrite, 0);
      check("rst_s_paddr", s_paddr, 0);
      check("rst_s_pwdata", s_pwdata, 0);
      check("rst_grant", grant, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_m0_pready", m0_pready, 0);
      check("rst_m0_prdata", m0_prdata, 0);
      check("rst_m1_pslverr", m1_pslverr, 0);
      tick(); rst_n = 1'b1;
      mid();
      check("idle_s_psel", s_psel, 0);

      // Single write from M0, zero-wait slave
      tick(); m_setup(0, 32'h5000_1000); m0_pwdata = 32'hDEAD_BEEF;
      mid();
      check("w_t_s_psel", s_psel, 0);
      tick(); m0_penable = 1'b1;
      mid();
      check("w_t1_s_psel", s_psel, 1);
      check("w_t1_s_penable", s_penable, 0);
      check("w_t1_s_paddr", s_paddr, 32'h5000_1000);
      check("w_t1_s_pwdata", s_pwdata, 32'hDEAD_BEEF);
      check("w_t1_s_pwrite", s_pwrite, 1);
      check("w_t1_m0_pready", m0_pready, 0);
      tick();
      mid();
      check("w_t2_s_penable", s_penable, 1);
      check("w_t2_m0_pready", m0_pready, 1);
      check("w_t2_m1_pready", m1_pready, 0);
      check("w_t2_grant", grant, 0);
      tick(); m0_psel = 1'b0; m0_penable = 1'b0;
      mid();
      check("w_t3_s_psel", s_psel, 0);
      check("w_t3_s_penable", s_penable, 0);
      check("w_t3_s_paddr_hold", s_paddr, 32'h5000_1000);
      check("w_t3_m0_pready", m0_pready, 0);

      // M1 read, three slave wait states, error response
      tick(); s_pready = 1'b0; m_setup(1, 32'h5000_2004); m1_pwrite = 1'b0;
      mid();
      check("r_t_m1_pready", m1_pready, 0);
      tick(); m1_penable = 1'b1;
      mid();
      check("r_t1_grant", grant, 1);
      check("r_t1_s_pwrite", s_pwrite, 0);
      check("r_t1_s_paddr", s_paddr, 32'h5000_2004);
      for (int k = 0; k < 3; k++) begin
         tick();
         mid();
         check("r_wait_m1_pready", m1_pready, 0);
         check("r_wait_s_penable", s_penable, 1);
      end
      tick(); s_pready = 1'b1; s_prdata = 32'h1234_5678; s_pslverr = 1'b1;
      mid();
      check("r_t5_m1_pready", m1_pready, 1);
      check("r_t5_m1_prdata", m1_prdata, 32'h1234_5678);
      check("r_t5_m1_pslverr", m1_pslverr, 1);
      check("r_t5_m0_pready", m0_pready, 0);
      check("r_t5_m0_prdata", m0_prdata, 0);
      check("r_t5_grant", grant, 1);
      check("r_t5_timeout_err", timeout_err, 0);
      tick(); m1_psel = 1'b0; m1_penable = 1'b0; s_pslverr = 1'b0;
      mid();
      check("r_t6_s_psel", s_psel, 0);
      check("r_t6_m1_pready", m1_pready, 0);

      // Contention: both masters keep requesting, four transfers each, strict alternation
      rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      base = 32'hA000_0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 0) begin
            m_setup(0, base);
            m_setup(1, base + 32'd1);
         end else if (i + 1 < 8) begin
            m_setup((i - 1) % 2, base + 32'(i + 1));
         end else begin
            m0_psel = 1'b0; m0_penable = 1'b0;
         end
         mid();
         check("rr_idle_s_psel", s_psel, 0);
         check("rr_idle_m0_pready", m0_pready, 0);
         check("rr_idle_m1_pready", m1_pready, 0);
         tick(); m0_penable = m0_psel; m1_penable = m1_psel;
         mid();
         check("rr_setup_grant", grant, 32'(i % 2));
         tick();
         mid();
         wp = (i % 2 == 0) ? m0_pready : m1_pready;
         lp = (i % 2 == 0) ? m1_pready : m0_pready;
         check("rr_access_s_paddr", s_paddr, base + 32'(i));
         check("rr_access_winner_pready", wp, 1);
         check("rr_access_waiter_pready", lp, 0);
      end
      tick(); m1_psel = 1'b0; m1_penable = 1'b0;

      // Timeout: slave never ready, forced completion after four wait cycles
      s_pready = 1'b0; s_prdata = 32'hFFFF_FFFF; m_setup(0, 32'h5000_3000);
      mid();
      tick(); m0_penable = 1'b1;
      mid();
      check("to_setup_grant", grant, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         mid();
         check("to_wait_m0_pready", m0_pready, 0);
         check("to_wait_timeout_err", timeout_err, 0);
      end
      tick();
      mid();
      check("to_hit_m0_pready", m0_pready, 1);
      check("to_hit_m0_pslverr", m0_pslverr, 1);
      check("to_hit_m0_prdata", m0_prdata, 0);
      check("to_hit_timeout_err", timeout_err, 1);
      check("to_hit_m1_pready", m1_pready, 0);
      tick(); m0_psel = 1'b0; m0_penable = 1'b0; s_pready = 1'b1;
      mid();
      check("to_after_timeout_err", timeout_err, 0);
      check("to_after_s_psel", s_psel, 0);
      tick(); m_setup(1, 32'h5000_3004); m1_pwrite = 1'b0; s_prdata = 32'hCAFE_0001;
      mid();
      tick(); m1_penable = 1'b1;
      mid();
      tick();
      mid();
      check("to_next_m1_pready", m1_pready, 1);
      check("to_next_m1_prdata", m1_prdata, 32'hCAFE_0001);
      check("to_next_m1_pslverr", m1_pslverr, 0);
      check("to_next_timeout_err", timeout_err, 0);
      tick(); m1_psel = 1'b0; m1_penable = 1'b0;

      // Reset in the middle of an access phase
      mid();
      tick(); s_pready = 1'b0; m_setup(0, 32'h5000_4000); m_setup(1, 32'h5000_4004);
      mid();
      tick(); m0_penable = 1'b1; m1_penable = 1'b1;
      mid();
      check("rm_setup_grant", grant, 0);
      tick();
      mid();
      check("rm_access_s_penable", s_penable, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rm_rst_s_psel", s_psel, 0);
      check("rm_rst_s_penable", s_penable, 0);
      check("rm_rst_grant", grant, 0);
      check("rm_rst_m0_pready", m0_pready, 0);
      check("rm_rst_m1_pready", m1_pready, 0);
      tick(); rst_n = 1'b1; m0_psel = 1'b0; m0_penable = 1'b0; s_pready = 1'b1;
      mid();
      check("rm_idle_s_psel", s_psel, 0);
      tick();
      mid();
      check("rm_regrant_grant", grant, 1);
      check("rm_regrant_s_paddr", s_paddr, 32'h5000_4004);
      tick();
      mid();
      check("rm_done_m1_pready", m1_pready, 1);
      tick(); m1_psel = 1'b0; m1_penable = 1'b0;

      // Fixed priority: M0 re-requests after every completion, M1 waits until M0 idles
      rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      base = 32'hB000_0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) begin
            m_setup(0, base);
            m_setup(1, 32'hB000_0100);
         end else if (i < 3) begin
            m_setup(0, base + 32'(i));
         end else begin
            m0_psel = 1'b0; m0_penable = 1'b0;
         end
         mid();
         check("fp_idle_s_psel", fp_s_psel, 0);
         tick(); m0_penable = m0_psel; m1_penable = m1_psel;
         mid();
         check("fp_setup_grant", fp_grant, (i < 3) ? 32'd0 : 32'd1);
         tick();
         mid();
         check("fp_access_m0_pready", fp_m0_pready, (i < 3) ? 32'd1 : 32'd0);
         check("fp_access_m1_pready", fp_m1_pready, (i == 3) ? 32'd1 : 32'd0);
         check("fp_access_s_paddr", fp_s_paddr, (i < 3) ? base + 32'(i) : 32'hB000_0100);
      end
      tick(); m1_psel = 1'b0; m1_penable = 1'b0;
      mid();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
